candy_alu_mc: RTL and testbench

- Parametrised, handshaked successor to the single-issue candy ALU.
- Adds configurable width, a valid/ready interface, a registered multiply with high-half access, an iterative signed/unsigned divider with remainder, carry/zero flags and back-pressure.
- Sits in the execute stage; replaces the fixed-24-bit ALU and its stall wiring.

---
 rtl/candy_alu_mc_if.sv | 29 ++
 rtl/candy_alu_mc.sv | 176 +++++++++++++++++
 tb/tb_candy_alu_mc.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/candy_alu_mc_if.sv
// Execute-stage request/response bundle for the candy ALU.
// Both directions use valid/ready: a transfer happens on a clk edge where valid and ready are both high, and the sender holds its payload until then.
interface candy_alu_mc_if #(
    parameter int WIDTH = 24,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   aluop_i;
    logic [WIDTH-1:0] reg1_i;
    logic [WIDTH-1:0] reg2_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_o;
    logic             carry_o;
    logic             zero_o;
    logic             div_by_zero_o;
    logic             busy_o;

    modport master (
        output in_valid, aluop_i, reg1_i, reg2_i, out_ready,
        input  in_ready, out_valid, res_o, carry_o, zero_o, div_by_zero_o, busy_o
    );

    modport slave (
        input  in_valid, aluop_i, reg1_i, reg2_i, out_ready,
        output in_ready, out_valid, res_o, carry_o, zero_o, div_by_zero_o, busy_o
    );
endinterface

// File: rtl/candy_alu_mc.sv
// Handshaked execute-stage ALU: single-cycle logic/add/shift ops, two-cycle
// multiply, and a restoring divider that takes WIDTH+2 cycles per operation.
module candy_alu_mc #(
    parameter int WIDTH = 24,
    parameter int OPW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    candy_alu_mc_if.slave bus,
    output logic [1:0]    dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL2    = 2'd1,
        DIV_RUN = 2'd2,
        DIV_FIX = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   rdy_q, accept, is_mul, is_div, div_signed;
    logic [WIDTH-1:0] a, b, alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   sum, diff;

    logic             ov_q, carry_q, zero_q, dbz_q;
    logic [WIDTH-1:0] res_q;
    logic             wr_en, wr_carry, wr_dbz;
    logic [WIDTH-1:0] wr_res;

    logic [WIDTH-1:0]         ma_q, mb_q;
    logic                     mulh_q;
    logic signed [2*WIDTH-1:0] mx, my, prod;

    logic [WIDTH-1:0] rem_q, quot_q, dvs_q, mag_a, mag_b, q_fix, r_fix;
    logic [WIDTH:0]   trial;
    logic             neg_q_q, neg_r_q, want_rem_q, dz_q;
    logic [CW-1:0]    cnt_q;

    assign a          = bus.reg1_i;
    assign b          = bus.reg2_i;
    assign is_mul     = (bus.aluop_i == OPW'(10)) || (bus.aluop_i == OPW'(11));
    assign is_div     = (bus.aluop_i >= OPW'(12));
    assign div_signed = (bus.aluop_i == OPW'(12)) || (bus.aluop_i == OPW'(14));
    assign accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (bus.aluop_i)
            OPW'(0): alu_res = a & b;
            OPW'(1): alu_res = a | b;
            OPW'(2): alu_res = a ^ b;
            OPW'(3): alu_res = ~(a | b);
            OPW'(4): alu_res = ~a;
            OPW'(5): begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
            OPW'(6): begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
            // Full-width shift amounts: oversized shifts naturally give 0 or sign fill.
            OPW'(7): alu_res = a << b;
            OPW'(8): alu_res = a >> b;
            OPW'(9): alu_res = $unsigned($signed(a) >>> b);
            default: alu_res = '0;
        endcase
    end

    assign mx   = {{WIDTH{ma_q[WIDTH-1]}}, ma_q};
    assign my   = {{WIDTH{mb_q[WIDTH-1]}}, mb_q};
    assign prod = mx * my;

    // Divider works on magnitudes; signs are reapplied in DIV_FIX.
    assign mag_a = (div_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (div_signed && b[WIDTH-1]) ? -b : b;
    assign trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
    assign q_fix = dz_q ? '1 : (neg_q_q ? -quot_q : quot_q);
    assign r_fix = neg_r_q ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul)      state_d = MUL2;
                else if (accept && is_div) state_d = DIV_RUN;
            end
            MUL2:    state_d = IDLE;
            DIV_RUN: if (cnt_q == CW'(WIDTH - 1)) state_d = DIV_FIX;
            DIV_FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = rdy_q && (state_q == IDLE) && (!ov_q || bus.out_ready);
        bus.busy_o   = (state_q != IDLE);
        wr_en        = 1'b0;
        wr_res       = alu_res;
        wr_carry     = 1'b0;
        wr_dbz       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !is_mul && !is_div) begin
                    wr_en    = 1'b1;
                    wr_carry = alu_carry;
                end
            end
            MUL2: begin
                wr_en  = 1'b1;
                wr_res = mulh_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
            end
            DIV_FIX: begin
                wr_en  = 1'b1;
                wr_res = want_rem_q ? r_fix : q_fix;
                wr_dbz = dz_q;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q <= 1'b0;   ov_q <= 1'b0;    res_q <= '0;
            carry_q <= 1'b0; zero_q <= 1'b0;  dbz_q <= 1'b0;
            ma_q <= '0;      mb_q <= '0;      mulh_q <= 1'b0;
            rem_q <= '0;     quot_q <= '0;    dvs_q <= '0;
            neg_q_q <= 1'b0; neg_r_q <= 1'b0; want_rem_q <= 1'b0;
            dz_q <= 1'b0;    cnt_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (ov_q && bus.out_ready) ov_q <= 1'b0;
            if (accept) begin
                ma_q       <= a;
                mb_q       <= b;
                mulh_q     <= (bus.aluop_i == OPW'(11));
                rem_q      <= '0;
                quot_q     <= mag_a;
                dvs_q      <= mag_b;
                neg_r_q    <= div_signed && a[WIDTH-1];
                neg_q_q    <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                want_rem_q <= (bus.aluop_i == OPW'(14)) || (bus.aluop_i == OPW'(15));
                dz_q       <= (b == '0);
                cnt_q      <= '0;
            end
            if (state_q == DIV_RUN) begin
                cnt_q <= cnt_q + 1'b1;
                if (!trial[WIDTH]) begin
                    rem_q  <= trial[WIDTH-1:0];
                    quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q  <= {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
                    quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                end
            end
            if (wr_en) begin
                ov_q    <= 1'b1;
                res_q   <= wr_res;
                carry_q <= wr_carry;
                zero_q  <= (wr_res == '0);
                dbz_q   <= wr_dbz;
            end
        end
    end

    assign bus.out_valid     = ov_q;
    assign bus.res_o         = res_q;
    assign bus.carry_o       = carry_q;
    assign bus.zero_o        = zero_q;
    assign bus.div_by_zero_o = dbz_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_candy_alu_mc.sv
// Directed-vector bench for candy_alu_mc: a driver pushes expected results into a queue,
// and a monitor pops and checks them on each output handshake.
module tb_candy_alu_mc;
  localparam int W = 24;
  localparam int OPW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  candy_alu_mc_if #(.WIDTH(W), .OPW(OPW)) bus ();
  candy_alu_mc #(.WIDTH(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];   // {dbz, carry, res}
  int acc_q[$];
  int lat_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  bit seen = 1'b0;
  int first_cyc = 0;
  logic [W+1:0] mon_e;
  int mon_t, mon_l;

  always @(negedge clk) begin
    if (!rst) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (bus.out_ready) begin
        seen = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got res %h with nothing issued, required no output", bus.res_o);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = acc_q.pop_front();
          mon_l = lat_q.pop_front();
          check("res", bus.res_o, mon_e[W-1:0]);
          check("carry", W'(bus.carry_o), W'(mon_e[W]));
          check("div_by_zero", W'(bus.div_by_zero_o), W'(mon_e[W+1]));
          check("zero", W'(bus.zero_o), W'(mon_e[W-1:0] == '0));
          check("latency", W'(first_cyc - mon_t), W'(mon_l));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic [W-1:0] r, input logic c, input logic d, input int lat,
                       input bit push = 1'b1);
    int waited;
    bus.in_valid = 1'b1;
    bus.aluop_i  = op;
    bus.reg1_i   = ra;
    bus.reg2_i   = rb;
    @(negedge clk);
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", waited);
    end else if (push) begin
      exp_q.push_back({d, c, r});
      acc_q.push_back(cyc);
      lat_q.push_back(lat);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  int t0, busy_cnt, late_cnt;

  initial begin
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.aluop_i   = 4'h5;
    bus.reg1_i    = 24'h000001;
    bus.reg2_i    = 24'h000001;
    rst = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), W'(0));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_busy", W'(bus.busy_o), W'(0));
    check("rst_res", bus.res_o, 24'h000000);
    check("rst_carry", W'(bus.carry_o), W'(0));
    check("rst_zero", W'(bus.zero_o), W'(0));
    check("rst_dbz", W'(bus.div_by_zero_o), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", W'(bus.in_ready), W'(1));
    check("post_rst_out_valid", W'(bus.out_valid), W'(0));
    tick(1);

    // single-cycle ops, back to back
    t0 = cyc;
    issue(4'h5, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0, 1);
    issue(4'h6, 24'h000003, 24'h000005, 24'hFFFFFE, 1'b1, 1'b0, 1);
    issue(4'h5, 24'h000001, 24'h000002, 24'h000003, 1'b0, 1'b0, 1);
    issue(4'h0, 24'hF0F0F0, 24'h3C3C3C, 24'h303030, 1'b0, 1'b0, 1);
    check("throughput_cycles", W'(cyc - t0), W'(4));
    issue(4'h1, 24'hF0F0F0, 24'h3C3C3C, 24'hFCFCFC, 1'b0, 1'b0, 1);
    issue(4'h3, 24'hF0F0F0, 24'h3C3C3C, 24'h030303, 1'b0, 1'b0, 1);
    issue(4'h4, 24'h123456, 24'h000000, 24'hEDCBA9, 1'b0, 1'b0, 1);
    issue(4'h9, 24'h800000, 24'd30,     24'hFFFFFF, 1'b0, 1'b0, 1);
    issue(4'h8, 24'h800000, 24'd30,     24'h000000, 1'b0, 1'b0, 1);
    issue(4'h7, 24'h000001, 24'd23,     24'h800000, 1'b0, 1'b0, 1);
    issue(4'h9, 24'h800000, 24'd4,      24'hF80000, 1'b0, 1'b0, 1);
    issue(4'h7, 24'h000001, 24'd24,     24'h000000, 1'b0, 1'b0, 1);
    drain();

    // multiply
    issue(4'hA, 24'h001000, 24'h001000, 24'h000000, 1'b0, 1'b0, 2);
    issue(4'hB, 24'h001000, 24'h001000, 24'h000001, 1'b0, 1'b0, 2);
    issue(4'hB, 24'hFFFFFF, 24'h000002, 24'hFFFFFF, 1'b0, 1'b0, 2);
    issue(4'hA, 24'h000123, 24'h000010, 24'h001230, 1'b0, 1'b0, 2);
    drain();

    // divide, with busy window on the first one
    issue(4'hD, 24'd100, 24'd7, 24'd14, 1'b0, 1'b0, 26);
    busy_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
    end
    check("div_busy_cycles", W'(busy_cnt), W'(25));
    @(negedge clk);
    check("div_busy_end", W'(bus.busy_o), W'(0));
    tick(1);
    issue(4'hF, 24'd100,    24'd7,      24'd2,      1'b0, 1'b0, 26);
    issue(4'hC, 24'hFFFFF9, 24'h000002, 24'hFFFFFD, 1'b0, 1'b0, 26);
    issue(4'hE, 24'hFFFFF9, 24'h000002, 24'hFFFFFF, 1'b0, 1'b0, 26);
    issue(4'hC, 24'h800000, 24'hFFFFFF, 24'h800000, 1'b0, 1'b0, 26);
    issue(4'hE, 24'h800000, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 26);
    issue(4'hD, 24'd5,      24'd0,      24'hFFFFFF, 1'b0, 1'b1, 26);
    issue(4'hF, 24'd5,      24'd0,      24'd5,      1'b0, 1'b1, 26);
    issue(4'hC, 24'hFFFFF9, 24'd0,      24'hFFFFFF, 1'b0, 1'b1, 26);
    issue(4'hE, 24'hFFFFF9, 24'd0,      24'hFFFFF9, 1'b0, 1'b1, 26);
    drain();

    // back-pressure: result held, no second accept
    bus.out_ready = 1'b0;
    issue(4'h2, 24'h0F0F0F, 24'h00FF00, 24'h0FF00F, 1'b0, 1'b0, 1);
    bus.in_valid = 1'b1;
    bus.aluop_i  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", W'(bus.out_valid), W'(1));
      check("bp_res_held", bus.res_o, 24'h0FF00F);
      check("bp_in_ready", W'(bus.in_ready), W'(0));
    end
    bus.in_valid = 1'b0;
    tick(1);
    bus.out_ready = 1'b1;
    drain();

    // abort a divide with reset
    issue(4'hD, 24'd100, 24'd7, 24'd14, 1'b0, 1'b0, 26, 1'b0);
    tick(8);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", W'(bus.out_valid), W'(0));
    check("abort_busy", W'(bus.busy_o), W'(0));
    check("abort_in_ready", W'(bus.in_ready), W'(0));
    check("abort_res", bus.res_o, 24'h000000);
    rst = 1'b1;
    late_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) late_cnt++;
    end
    check("abort_no_result", W'(late_cnt), W'(0));
    check("queue_empty", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
